mdio_master_serializer: RTL and testbench



---
 rtl/mdio_master_serializer.sv | 189 ++++++++++++++++++
 tb/tb_mdio_master_serializer.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdio_master_serializer.sv
// MDIO station-management master: parallel ops in, Clause 22/45 frames out.
// Build option MDIO_PREAMBLE_SUPPRESS_EN drops the 32-bit preamble.
module mdio_master_serializer #(
  parameter int MDC_HALF = 25
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        clause_sel_i,
  output logic        ready_o,
  input  logic        valid_i,
  input  logic [1:0]  cmd_i,
  input  logic [25:0] addr_i,
  input  logic [15:0] wdata_i,
  output logic        rdata_vld_o,
  output logic [15:0] rdata_o,
  output logic        MDC,
  inout  wire         MDIO
);

  localparam int HALF = (MDC_HALF < 1) ? 1 : MDC_HALF;
  localparam int HW = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [HW-1:0] HLAST = HW'(HALF - 1);

`ifdef MDIO_PREAMBLE_SUPPRESS_EN
  localparam logic [5:0] BIT0 = 6'd32;
`else
  localparam logic [5:0] BIT0 = 6'd0;
`endif

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    PRE,
    ST_OP,
    ADDR,
    TA,
    DATA,
    DONE
  } state_e;

  state_e          state_q, state_d;
  logic            ready_q, ready_d;
  logic            vld_q, vld_d;
  logic [15:0]     rdata_q, rdata_d;
  logic            mdc_q, mdc_d;
  logic            oe_q, oe_d;
  logic [63:0]     sreg_q, sreg_d;
  logic [HW-1:0]   hcnt_q, hcnt_d;
  logic [5:0]      bit_q, bit_d;
  logic            rd_q, rd_d;
  logic [15:0]     rsh_q, rsh_d;

  logic [1:0]      st_w, op_w;
  logic [15:0]     dat_w;
  logic [63:0]     frame_w;
  logic [5:0]      nbit;
  logic            mdio_in;
  logic            accept;

  assign MDIO    = oe_q ? sreg_q[63] : 1'bz;
  assign mdio_in = MDIO;
  assign MDC     = mdc_q;
  assign ready_o = ready_q;
  assign rdata_vld_o = vld_q;
  assign rdata_o = rdata_q;
  assign nbit    = bit_q + 6'd1;

  function automatic state_e bit_state(input logic [5:0] b);
    state_e s;
    s = DATA;
    unique case (1'b1)
      (b < 6'd32):                s = PRE;
      (b >= 6'd32 && b < 6'd36):  s = ST_OP;
      (b >= 6'd36 && b < 6'd46):  s = ADDR;
      (b >= 6'd46 && b < 6'd48):  s = TA;
      (b >= 6'd48):               s = DATA;
    endcase
    return s;
  endfunction

  // C45 address frames carry the address payload in the data field
  always_comb begin
    st_w = clause_sel_i ? 2'b00 : 2'b01;
    if (clause_sel_i) begin
      op_w = cmd_i;
    end else begin
      op_w = (cmd_i == 2'b01) ? 2'b01 : 2'b10;
    end
    dat_w = (clause_sel_i && cmd_i == 2'b00) ? addr_i[15:0] : wdata_i;
    frame_w = {32'hFFFF_FFFF, st_w, op_w, addr_i[25:21],
               addr_i[20:16], 2'b10, dat_w};
  end

  assign accept = valid_i && ready_q &&
                  (clause_sel_i || cmd_i != 2'b00);

  always_comb begin
    state_d = state_q;
    ready_d = ready_q;
    vld_d   = 1'b0;
    rdata_d = rdata_q;
    mdc_d   = mdc_q;
    oe_d    = oe_q;
    sreg_d  = sreg_q;
    hcnt_d  = hcnt_q;
    bit_d   = bit_q;
    rd_d    = rd_q;
    rsh_d   = rsh_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = LOAD;
          ready_d = 1'b0;
          rd_d    = cmd_i[1];
          sreg_d  = frame_w << BIT0;
        end
      end
      LOAD: begin
        state_d = bit_state(BIT0);
        bit_d   = BIT0;
        hcnt_d  = '0;
        mdc_d   = 1'b0;
        oe_d    = 1'b1;
      end
      PRE, ST_OP, ADDR, TA, DATA: begin
        if (hcnt_q != HLAST) begin
          hcnt_d = hcnt_q + 1'b1;
        end else begin
          hcnt_d = '0;
          if (!mdc_q) begin
            mdc_d = 1'b1;
          end else begin
            mdc_d = 1'b0;
            if (bit_q == 6'd63) begin
              state_d = DONE;
              oe_d    = 1'b0;
              if (rd_q) begin
                vld_d   = 1'b1;
                rdata_d = rsh_q;
              end
            end else begin
              bit_d   = nbit;
              sreg_d  = {sreg_q[62:0], 1'b0};
              state_d = bit_state(nbit);
              oe_d    = !(rd_q && nbit >= 6'd46);
            end
          end
        end
        // sample in the first clk cycle of the MDC high phase
        if (state_q == DATA && rd_q && mdc_q && hcnt_q == '0) begin
          rsh_d = {rsh_q[14:0], mdio_in};
        end
      end
      DONE: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      ready_q <= 1'b1;
      vld_q   <= 1'b0;
      rdata_q <= '0;
      mdc_q   <= 1'b0;
      oe_q    <= 1'b0;
      sreg_q  <= '0;
      hcnt_q  <= '0;
      bit_q   <= '0;
      rd_q    <= 1'b0;
      rsh_q   <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      vld_q   <= vld_d;
      rdata_q <= rdata_d;
      mdc_q   <= mdc_d;
      oe_q    <= oe_d;
      sreg_q  <= sreg_d;
      hcnt_q  <= hcnt_d;
      bit_q   <= bit_d;
      rd_q    <= rd_d;
      rsh_q   <= rsh_d;
    end
  end

endmodule

// File: tb/tb_mdio_master_serializer.sv
// Directed bench for mdio_master_serializer (MDC_HALF=25 and MDC_HALF=2).
module tb_mdio_master_serializer;

`ifdef MDIO_PREAMBLE_SUPPRESS_EN
  localparam int NB = 32;
`else
  localparam int NB = 64;
`endif
  localparam int OFF = 64 - NB;
  localparam logic [31:0] PRE_W = (NB == 64) ? 32'hFFFF_FFFF : 32'h0;

  logic clk = 1'b0;
  logic rstn = 1'b0;

  logic        a_sel, a_valid, a_ready, a_vld, a_mdc;
  logic [1:0]  a_cmd;
  logic [25:0] a_addr;
  logic [15:0] a_wdata, a_rdata;
  wire         a_mdio;
  logic        phy_oe_a, phy_val_a;

  logic        b_sel, b_valid, b_ready, b_vld, b_mdc;
  logic [1:0]  b_cmd;
  logic [25:0] b_addr;
  logic [15:0] b_wdata, b_rdata;
  wire         b_mdio;

  int n_checks = 0;
  int n_err = 0;

  assign a_mdio = phy_oe_a ? phy_val_a : 1'bz;
  pullup (a_mdio);
  pullup (b_mdio);

  always #5 clk = ~clk;

  mdio_master_serializer #(.MDC_HALF(25)) dut_a (
    .clk_i(clk), .rstn_i(rstn), .clause_sel_i(a_sel),
    .ready_o(a_ready), .valid_i(a_valid), .cmd_i(a_cmd),
    .addr_i(a_addr), .wdata_i(a_wdata), .rdata_vld_o(a_vld),
    .rdata_o(a_rdata), .MDC(a_mdc), .MDIO(a_mdio)
  );

  mdio_master_serializer #(.MDC_HALF(2)) dut_b (
    .clk_i(clk), .rstn_i(rstn), .clause_sel_i(b_sel),
    .ready_o(b_ready), .valid_i(b_valid), .cmd_i(b_cmd),
    .addr_i(b_addr), .wdata_i(b_wdata), .rdata_vld_o(b_vld),
    .rdata_o(b_rdata), .MDC(b_mdc), .MDIO(b_mdio)
  );

  task automatic run_frame(
    input  logic        sel,
    input  logic [1:0]  cmd,
    input  logic [25:0] addr,
    input  logic [15:0] wd,
    input  logic        phy_en,
    input  logic [15:0] phy_d,
    input  int          pulse_at,
    output logic [63:0] bits,
    output int          busy,
    output int          nvld,
    output logic [15:0] vdat,
    output logic        tmo
  );
    int cyc, nrise, idx;
    logic pm;
    bits = '0; busy = 0; nvld = 0; vdat = '0; tmo = 1'b1; nrise = 0;
    @(negedge clk);
    a_sel = sel; a_cmd = cmd; a_addr = addr; a_wdata = wd;
    a_valid = 1'b1;
    @(negedge clk);
    a_valid = 1'b0;
    pm = a_mdc;
    for (cyc = 0; cyc < 5000; cyc++) begin
      if (cyc == pulse_at) begin
        a_valid = 1'b1; a_cmd = 2'b01;
        a_addr = '1; a_wdata = 16'hFFFF;
      end else begin
        a_valid = 1'b0;
      end
      if (a_ready) begin
        tmo = 1'b0;
        break;
      end
      busy++;
      if (a_vld) begin
        nvld++;
        vdat = a_rdata;
      end
      if (a_mdc && !pm) begin
        bits = {bits[62:0], a_mdio};
        nrise++;
      end
      if (!a_mdc && pm) begin
        idx = nrise + OFF;
        phy_oe_a = phy_en && idx >= 47 && idx <= 63;
        if (idx >= 48 && idx <= 63) phy_val_a = phy_d[63-idx];
        else phy_val_a = 1'b0;
      end
      pm = a_mdc;
      @(negedge clk);
    end
    a_valid = 1'b0;
    phy_oe_a = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks++;
    if (a_ready !== 1'b1 || a_vld !== 1'b0 || a_mdc !== 1'b0) begin
      n_err++;
      $display("FAIL reset_ctl: rdy=%b vld=%b mdc=%b need 1 0 0",
               a_ready, a_vld, a_mdc);
    end
    n_checks++;
    if (a_rdata !== 16'h0) begin
      n_err++;
      $display("FAIL reset_rdata: got %h need 0000", a_rdata);
    end
    phy_oe_a = 1'b1; phy_val_a = 1'b0; #1;
    n_checks++;
    if (a_mdio !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mdio_rel: got %b need 0 (phy low)", a_mdio);
    end
    phy_oe_a = 1'b0; #1;
    n_checks++;
    if (a_mdio !== 1'b1 || b_mdio !== 1'b1 || b_mdc !== 1'b0) begin
      n_err++;
      $display("FAIL reset_idle: a=%b b=%b bmdc=%b need 1 1 0",
               a_mdio, b_mdio, b_mdc);
    end
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_c22_write();
    logic [63:0] bits; int busy, nvld; logic [15:0] vd; logic to;
    run_frame(1'b0, 2'b01, {5'h1f, 5'h0d, 16'h0}, 16'h4000,
              1'b0, 16'h0, -1, bits, busy, nvld, vd, to);
    n_checks++;
    if (to !== 1'b0) begin
      n_err++; $display("FAIL c22w_timeout: got %b need 0", to);
    end
    n_checks++;
    if (bits !== {PRE_W, 32'h5FB6_4000}) begin
      n_err++;
      $display("FAIL c22w_bits: got %h need %h", bits,
               {PRE_W, 32'h5FB6_4000});
    end
    n_checks++;
    if (busy !== NB * 50 + 2) begin
      n_err++;
      $display("FAIL c22w_busy: got %0d need %0d", busy, NB * 50 + 2);
    end
    n_checks++;
    if (nvld !== 0 || a_rdata !== 16'h0) begin
      n_err++;
      $display("FAIL c22w_vld: got %0d/%h need 0/0000", nvld, a_rdata);
    end
  endtask

  task automatic test_c22_read();
    logic [63:0] bits; int busy, nvld; logic [15:0] vd; logic to;
    run_frame(1'b0, 2'b11, {5'h1f, 5'h0e, 16'h0}, 16'h0,
              1'b1, 16'h5a5a, -1, bits, busy, nvld, vd, to);
    n_checks++;
    if (to !== 1'b0 || bits !== {PRE_W, 32'h6FBA_5A5A}) begin
      n_err++;
      $display("FAIL c22r_bits: got %h to=%b need %h", bits, to,
               {PRE_W, 32'h6FBA_5A5A});
    end
    n_checks++;
    if (nvld !== 1 || vd !== 16'h5a5a) begin
      n_err++;
      $display("FAIL c22r_vld: got %0d/%h need 1/5a5a", nvld, vd);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (a_rdata !== 16'h5a5a || a_vld !== 1'b0) begin
      n_err++;
      $display("FAIL c22r_hold: got %h vld=%b need 5a5a 0",
               a_rdata, a_vld);
    end
  endtask

  task automatic test_c45_addr();
    logic [63:0] bits; int busy, nvld; logic [15:0] vd; logic to;
    a_sel = 1'b1;
    run_frame(1'b1, 2'b00, {5'h03, 5'h01, 16'h0004}, 16'hFFFF,
              1'b0, 16'h0, -1, bits, busy, nvld, vd, to);
    n_checks++;
    if (to !== 1'b0 || bits !== {PRE_W, 32'h0186_0004}) begin
      n_err++;
      $display("FAIL c45a_bits: got %h to=%b need %h", bits, to,
               {PRE_W, 32'h0186_0004});
    end
    n_checks++;
    if (nvld !== 0 || busy !== NB * 50 + 2) begin
      n_err++;
      $display("FAIL c45a_busy: vld=%0d busy=%0d need 0 %0d",
               nvld, busy, NB * 50 + 2);
    end
  endtask

  task automatic test_c45_read_inc();
    logic [63:0] bits; int busy, nvld; logic [15:0] vd; logic to;
    run_frame(1'b1, 2'b10, {5'h03, 5'h01, 16'h0}, 16'h0,
              1'b1, 16'h1234, -1, bits, busy, nvld, vd, to);
    n_checks++;
    if (to !== 1'b0 || bits !== {PRE_W, 32'h2186_1234}) begin
      n_err++;
      $display("FAIL c45r_bits: got %h to=%b need %h", bits, to,
               {PRE_W, 32'h2186_1234});
    end
    n_checks++;
    if (nvld !== 1 || vd !== 16'h1234) begin
      n_err++;
      $display("FAIL c45r_vld: got %0d/%h need 1/1234", nvld, vd);
    end
  endtask

  task automatic test_busy();
    logic [63:0] bits; int busy, nvld, bad; logic [15:0] vd; logic to;
    run_frame(1'b0, 2'b01, {5'h1f, 5'h0d, 16'h0}, 16'h4000,
              1'b0, 16'h0, 1000, bits, busy, nvld, vd, to);
    n_checks++;
    if (to !== 1'b0 || bits !== {PRE_W, 32'h5FB6_4000}) begin
      n_err++;
      $display("FAIL busy_bits: got %h to=%b need %h", bits, to,
               {PRE_W, 32'h5FB6_4000});
    end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (a_ready !== 1'b1 || a_mdc !== 1'b0) bad++;
      @(negedge clk);
    end
    n_checks++;
    if (bad !== 0 || busy !== NB * 50 + 2) begin
      n_err++;
      $display("FAIL busy_ignored: bad=%0d busy=%0d need 0 %0d",
               bad, busy, NB * 50 + 2);
    end
  endtask

  task automatic test_cmd00();
    int bad;
    bad = 0;
    a_sel = 1'b0; a_cmd = 2'b00; a_valid = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (a_ready !== 1'b1 || a_mdc !== 1'b0) bad++;
    end
    a_valid = 1'b0;
    n_checks++;
    if (bad !== 0) begin
      n_err++;
      $display("FAIL cmd00_reject: bad cycles=%0d need 0", bad);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [63:0] bits; int busy, nvld, n, cyc; logic [15:0] vd;
    logic to, pm;
    @(negedge clk);
    a_sel = 1'b0; a_cmd = 2'b01; a_addr = {5'h02, 5'h03, 16'h0};
    a_wdata = 16'hFFFF; a_valid = 1'b1;
    @(negedge clk);
    a_valid = 1'b0;
    n = 0; cyc = 0; pm = a_mdc;
    while (n < NB - 12 && cyc < 5000) begin
      @(negedge clk);
      if (a_mdc && !pm) n++;
      pm = a_mdc;
      cyc++;
    end
    n_checks++;
    if (cyc >= 5000) begin
      n_err++; $display("FAIL rstmid_timeout: rises=%0d need %0d", n, NB - 12);
    end
    #2 rstn = 1'b0;
    #1;
    n_checks++;
    if (a_mdc !== 1'b0 || a_ready !== 1'b1 || a_rdata !== 16'h0) begin
      n_err++;
      $display("FAIL rstmid_out: mdc=%b rdy=%b rd=%h need 0 1 0000",
               a_mdc, a_ready, a_rdata);
    end
    phy_oe_a = 1'b1; phy_val_a = 1'b0; #1;
    n_checks++;
    if (a_mdio !== 1'b0) begin
      n_err++;
      $display("FAIL rstmid_mdio: got %b need 0 (released)", a_mdio);
    end
    phy_oe_a = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    run_frame(1'b0, 2'b01, {5'h1f, 5'h0d, 16'h0}, 16'h4000,
              1'b0, 16'h0, -1, bits, busy, nvld, vd, to);
    n_checks++;
    if (to !== 1'b0 || bits !== {PRE_W, 32'h5FB6_4000} ||
        busy !== NB * 50 + 2) begin
      n_err++;
      $display("FAIL rstmid_refr: got %h busy=%0d need %h %0d", bits,
               busy, {PRE_W, 32'h5FB6_4000}, NB * 50 + 2);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] bits1, bits2;
    int busy1, busy2, cyc, t, first_hi, rises, last_rise, hi_run, bad;
    logic pm, r_mdc;
    bits1 = '0; bits2 = '0; busy1 = 0; busy2 = 0;
    @(negedge clk);
    b_sel = 1'b0; b_cmd = 2'b01; b_addr = {5'h01, 5'h02, 16'h0};
    b_wdata = 16'h1234; b_valid = 1'b1;
    @(negedge clk);
    b_valid = 1'b0;
    pm = b_mdc; cyc = 0;
    while (!b_ready && cyc < 2000) begin
      busy1++;
      if (b_mdc && !pm) bits1 = {bits1[62:0], b_mdio};
      pm = b_mdc;
      cyc++;
      @(negedge clk);
    end
    r_mdc = b_mdc;
    b_addr = {5'h05, 5'h1b, 16'h0}; b_wdata = 16'hBEEF; b_valid = 1'b1;
    @(negedge clk);
    b_valid = 1'b0;
    t = 1; first_hi = -1; rises = 0; last_rise = -1; hi_run = 0;
    bad = 0; pm = 1'b0;
    while (!b_ready && t < 2000) begin
      busy2++;
      if (b_mdc && first_hi < 0) first_hi = t;
      if (b_mdc && !pm) begin
        bits2 = {bits2[62:0], b_mdio};
        if (last_rise >= 0 && t - last_rise != 4) bad++;
        last_rise = t;
        rises++;
      end
      if (b_mdc) hi_run++;
      else begin
        if (pm && hi_run != 2) bad++;
        hi_run = 0;
      end
      pm = b_mdc;
      t++;
      @(negedge clk);
    end
    n_checks++;
    if (cyc >= 2000 || t >= 2000) begin
      n_err++; $display("FAIL b2b_timeout: c=%0d t=%0d need <2000", cyc, t);
    end
    n_checks++;
    if (bits1 !== {PRE_W, 32'h508A_1234} || busy1 !== NB * 4 + 2) begin
      n_err++;
      $display("FAIL b2b_f1: got %h busy=%0d need %h %0d", bits1, busy1,
               {PRE_W, 32'h508A_1234}, NB * 4 + 2);
    end
    n_checks++;
    if (bits2 !== {PRE_W, 32'h52EE_BEEF} || busy2 !== NB * 4 + 2) begin
      n_err++;
      $display("FAIL b2b_f2: got %h busy=%0d need %h %0d", bits2, busy2,
               {PRE_W, 32'h52EE_BEEF}, NB * 4 + 2);
    end
    n_checks++;
    if (first_hi !== 4 || r_mdc !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_gap: first_hi=%0d mdc@rdy=%b need 4 0",
               first_hi, r_mdc);
    end
    n_checks++;
    if (bad !== 0 || rises !== NB) begin
      n_err++;
      $display("FAIL b2b_mdc: bad=%0d rises=%0d need 0 %0d",
               bad, rises, NB);
    end
  endtask

  initial begin
    a_sel = 1'b0; a_valid = 1'b0; a_cmd = 2'b00; a_addr = '0;
    a_wdata = '0; phy_oe_a = 1'b0; phy_val_a = 1'b0;
    b_sel = 1'b0; b_valid = 1'b0; b_cmd = 2'b00; b_addr = '0;
    b_wdata = '0;
    test_reset();
    test_c22_write();
    test_c22_read();
    test_c45_addr();
    test_c45_read_inc();
    test_busy();
    test_cmd00();
    test_reset_mid_frame();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_err);
    $finish;
  end

endmodule
